// File: rtl/risc_v_pkg.sv
// Shared constants for the fetch front end: default widths, reset PC and the
// canonical RISC-V NOP (addi x0, x0, 0) shown to ID when nothing is queued.
package risc_v_pkg;
  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/risc_v_fetch_queue_fifo.sv
// Small power-of-two FIFO with a combinational head read from registered storage.
// Flush clears the pointers only; stale storage is never visible because count gates it.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/risc_v_fetch_queue.sv
// IF stage with a DEPTH-entry IF/ID queue: owns the PC, issues in-order fetches,
// and discards responses that were already in flight when a redirect happened.
module risc_v_fetch_queue
  import risc_v_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  localparam int             CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PC_Branch,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_VALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  input  logic            ID_ready,
  output logic            VALID_ID,
  output logic [XLEN-1:0] PC_ID,
  output logic [XLEN-1:0] INSTRUCTION_ID,
  output logic [CW-1:0]   COUNT
);
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CW-1:0]     inflight_q, inflight_d, drop_q, drop_d;
  logic [CW:0]       occupancy;
  logic              valid_rsp, pay_push, pay_pop;
  logic              pay_full, pay_empty, addr_full, addr_empty;
  logic [CW-1:0]     pay_count, addr_count;
  logic [XLEN-1:0]   rsp_addr;
  logic [2*XLEN-1:0] head;

  // A pop in the same cycle is deliberately not credited, so a push can never overflow.
  assign occupancy = {1'b0, pay_count} + {1'b0, inflight_q};
  assign IMEM_REQ  = !reset && !PCSrc && (occupancy < (CW+1)'(DEPTH));
  assign IMEM_ADDR = pc_q;
  assign valid_rsp = IMEM_VALID && (inflight_q != '0);
  assign pay_push  = valid_rsp && (drop_q == '0) && !PCSrc;
  assign pay_pop   = ID_ready && !pay_empty && !PCSrc;

  // Address queue is never flushed: dropped responses still pop their own address.
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_addr_fifo (
    .clk(clk), .reset(reset), .flush(1'b0), .push(IMEM_REQ), .wdata(pc_q),
    .pop(valid_rsp), .rdata(rsp_addr), .full(addr_full), .empty(addr_empty),
    .count(addr_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_pay_fifo (
    .clk(clk), .reset(reset), .flush(PCSrc), .push(pay_push),
    .wdata({rsp_addr, IMEM_RDATA}), .pop(pay_pop), .rdata(head),
    .full(pay_full), .empty(pay_empty), .count(pay_count)
  );

  assign VALID_ID       = !pay_empty;
  assign PC_ID          = VALID_ID ? head[2*XLEN-1:XLEN] : '0;
  assign INSTRUCTION_ID = VALID_ID ? head[XLEN-1:0] : XLEN'(NOP_INSTR);
  assign COUNT          = pay_count;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(IMEM_REQ) - CW'(valid_rsp);
    drop_d     = drop_q;
    if (PCSrc) begin
      pc_d   = {PC_Branch[XLEN-1:2], 2'b00};
      drop_d = inflight_q - CW'(valid_rsp);
    end else begin
      if (IMEM_REQ) pc_d = pc_q + XLEN'(4);
      if (valid_rsp && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(IMEM_VALID && inflight_q == '0)) else $error("IMEM_VALID with nothing in flight");
      assert (addr_count == inflight_q) else $error("address queue out of step with inflight");
      assert (!(valid_rsp && addr_empty)) else $error("response without tracked address");
      assert (!(IMEM_REQ && addr_full)) else $error("address queue overflow");
      assert (!(pay_push && pay_full && !pay_pop)) else $error("payload queue overflow");
    end
  end
endmodule

// File: tb/tb_risc_v_fetch_queue.sv
// Directed bench: DUT A (DEPTH=4) with a 1..3-cycle memory, DUT B (DEPTH=8)
// with a random 2-5 cycle in-order memory for the PC-wrap scenario.
module tb_risc_v_fetch_queue;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic        PCSrc_a = 0, IMEM_VALID_a = 0, ID_ready_a = 0;
  logic [31:0] PC_Branch_a = 0, IMEM_RDATA_a = 0;
  logic        IMEM_REQ_a, VALID_ID_a;
  logic [31:0] IMEM_ADDR_a, PC_ID_a, INSTRUCTION_ID_a;
  logic [2:0]  COUNT_a;

  logic        PCSrc_b = 0, IMEM_VALID_b = 0, ID_ready_b = 1;
  logic [31:0] PC_Branch_b = 0, IMEM_RDATA_b = 0;
  logic        IMEM_REQ_b, VALID_ID_b;
  logic [31:0] IMEM_ADDR_b, PC_ID_b, INSTRUCTION_ID_b;
  logic [3:0]  COUNT_b;

  risc_v_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .reset(reset), .PCSrc(PCSrc_a), .PC_Branch(PC_Branch_a),
    .IMEM_REQ(IMEM_REQ_a), .IMEM_ADDR(IMEM_ADDR_a), .IMEM_VALID(IMEM_VALID_a),
    .IMEM_RDATA(IMEM_RDATA_a), .ID_ready(ID_ready_a), .VALID_ID(VALID_ID_a),
    .PC_ID(PC_ID_a), .INSTRUCTION_ID(INSTRUCTION_ID_a), .COUNT(COUNT_a)
  );

  risc_v_fetch_queue #(.XLEN(32), .DEPTH(8), .RESET_PC(32'h0)) dut_b (
    .clk(clk), .reset(reset), .PCSrc(PCSrc_b), .PC_Branch(PC_Branch_b),
    .IMEM_REQ(IMEM_REQ_b), .IMEM_ADDR(IMEM_ADDR_b), .IMEM_VALID(IMEM_VALID_b),
    .IMEM_RDATA(IMEM_RDATA_b), .ID_ready(ID_ready_b), .VALID_ID(VALID_ID_b),
    .PC_ID(PC_ID_b), .INSTRUCTION_ID(INSTRUCTION_ID_b), .COUNT(COUNT_b)
  );

  int checks = 0, errors = 0;
  int unsigned cyc = 0;
  logic [31:0] qa_addr[$], qb_addr[$];
  int unsigned qa_due[$], qb_due[$];
  int unsigned lat_a = 1, last_a = 0, last_b = 0;
  logic obs_req_a;

  // One clock cycle: answer due requests, capture new ones, step to the next negedge.
  task automatic tick();
    int unsigned d;
    if (qa_due.size() > 0 && qa_due[0] <= cyc) begin
      d = qa_due.pop_front();
      IMEM_VALID_a = 1'b1;
      IMEM_RDATA_a = qa_addr.pop_front() >> 2;
    end else IMEM_VALID_a = 1'b0;
    if (qb_due.size() > 0 && qb_due[0] <= cyc) begin
      d = qb_due.pop_front();
      IMEM_VALID_b = 1'b1;
      IMEM_RDATA_b = qb_addr.pop_front() >> 2;
    end else IMEM_VALID_b = 1'b0;
    #1;
    obs_req_a = IMEM_REQ_a;
    if (IMEM_REQ_a) begin
      d = cyc + lat_a;
      if (qa_due.size() > 0 && d <= last_a) d = last_a + 1;
      qa_due.push_back(d); qa_addr.push_back(IMEM_ADDR_a); last_a = d;
    end
    if (IMEM_REQ_b) begin
      d = cyc + $urandom_range(2, 5);
      if (qb_due.size() > 0 && d <= last_b) d = last_b + 1;
      qb_due.push_back(d); qb_addr.push_back(IMEM_ADDR_b); last_b = d;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_mem();
    qa_addr.delete(); qa_due.delete(); qb_addr.delete(); qb_due.delete();
    IMEM_VALID_a = 0; IMEM_VALID_b = 0;
  endtask

  task automatic do_reset();
    reset = 1; PCSrc_a = 0; PCSrc_b = 0; clear_mem();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (VALID_ID_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", VALID_ID_a); end
    checks++; if (INSTRUCTION_ID_a !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", INSTRUCTION_ID_a, NOP); end
    checks++; if (COUNT_a !== 3'd0 || PC_ID_a !== 32'h0) begin errors++; $display("FAIL reset_count_pc got %0d/%h exp 0/0", COUNT_a, PC_ID_a); end
    checks++; if (IMEM_REQ_a !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", IMEM_REQ_a); end
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (IMEM_REQ_a !== 1'b1 || IMEM_ADDR_a !== 32'h0) begin errors++; $display("FAIL first_fetch got %0b/%h exp 1/0", IMEM_REQ_a, IMEM_ADDR_a); end
    $display("test_reset done");
  endtask

  task automatic test_reset_midrun();
    lat_a = 1; ID_ready_a = 0;
    repeat (4) tick();
    checks++; if (COUNT_a !== 3'd3) begin errors++; $display("FAIL midrun_fill got %0d exp 3", COUNT_a); end
    #2 reset = 1; IMEM_VALID_a = 0; IMEM_VALID_b = 0;
    #1;
    checks++; if (VALID_ID_a !== 1'b0 || INSTRUCTION_ID_a !== NOP || COUNT_a !== 3'd0) begin
      errors++; $display("FAIL midrun_async got %0b/%h/%0d exp 0/%h/0", VALID_ID_a, INSTRUCTION_ID_a, COUNT_a, NOP); end
    clear_mem();
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (IMEM_REQ_a !== 1'b1 || IMEM_ADDR_a !== 32'h0) begin errors++; $display("FAIL midrun_restart got %0b/%h exp 1/0", IMEM_REQ_a, IMEM_ADDR_a); end
    $display("test_reset_midrun done");
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc = 0;
    int got = 0;
    do_reset(); lat_a = 1; ID_ready_a = 1;
    repeat (12) begin
      tick();
      if (VALID_ID_a) begin
        checks++; if (PC_ID_a !== exp_pc || INSTRUCTION_ID_a !== (exp_pc >> 2)) begin
          errors++; $display("FAIL stream_entry got %h/%h exp %h/%h", PC_ID_a, INSTRUCTION_ID_a, exp_pc, exp_pc >> 2); end
        exp_pc += 4; got++;
      end
      checks++; if (COUNT_a > 3'd1) begin errors++; $display("FAIL stream_count got %0d exp <=1", COUNT_a); end
    end
    checks++; if (got != 11) begin errors++; $display("FAIL stream_throughput got %0d exp 11", got); end
    $display("test_streaming done entries=%0d", got);
  endtask

  task automatic test_backpressure();
    int maxc = 0;
    do_reset(); lat_a = 1; ID_ready_a = 0;
    repeat (10) begin
      tick();
      if (int'(COUNT_a) > maxc) maxc = int'(COUNT_a);
    end
    checks++; if (COUNT_a !== 3'd4 || maxc != 4) begin errors++; $display("FAIL bp_full got %0d max %0d exp 4", COUNT_a, maxc); end
    checks++; if (IMEM_REQ_a !== 1'b0) begin errors++; $display("FAIL bp_req got %0b exp 0", IMEM_REQ_a); end
    ID_ready_a = 1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (VALID_ID_a !== 1'b1 || PC_ID_a !== 32'(4*k) || INSTRUCTION_ID_a !== 32'(k)) begin
        errors++; $display("FAIL bp_order[%0d] got %0b/%h/%h exp 1/%h/%h", k, VALID_ID_a, PC_ID_a, INSTRUCTION_ID_a, 4*k, k); end
      tick();
    end
    $display("test_backpressure done");
  endtask

  task automatic test_redirect_inflight();
    int wait_n = 0;
    do_reset(); lat_a = 3; ID_ready_a = 1;
    tick(); tick();
    PCSrc_a = 1; PC_Branch_a = 32'h103;
    tick();
    checks++; if (obs_req_a !== 1'b0) begin errors++; $display("FAIL redir_req got %0b exp 0", obs_req_a); end
    PCSrc_a = 0; lat_a = 1;
    #1;
    checks++; if (COUNT_a !== 3'd0) begin errors++; $display("FAIL redir_count got %0d exp 0", COUNT_a); end
    checks++; if (IMEM_REQ_a !== 1'b1 || IMEM_ADDR_a !== 32'h100) begin errors++; $display("FAIL redir_addr got %0b/%h exp 1/100", IMEM_REQ_a, IMEM_ADDR_a); end
    while (!VALID_ID_a && wait_n < 10) begin tick(); wait_n++; end
    checks++; if (wait_n != 3 || PC_ID_a !== 32'h100 || INSTRUCTION_ID_a !== 32'h40) begin
      errors++; $display("FAIL redir_first got wait %0d pc %h instr %h exp 3/100/40", wait_n, PC_ID_a, INSTRUCTION_ID_a); end
    $display("test_redirect_inflight done");
  endtask

  task automatic test_redirect_collision();
    do_reset(); lat_a = 1; ID_ready_a = 1;
    repeat (4) tick();
    checks++; if (VALID_ID_a !== 1'b1 || PC_ID_a !== 32'h8) begin errors++; $display("FAIL coll_pre got %0b/%h exp 1/8", VALID_ID_a, PC_ID_a); end
    PCSrc_a = 1; PC_Branch_a = 32'h200;
    tick();
    PCSrc_a = 0;
    #1;
    checks++; if (obs_req_a !== 1'b0 || COUNT_a !== 3'd0 || VALID_ID_a !== 1'b0 || INSTRUCTION_ID_a !== NOP) begin
      errors++; $display("FAIL coll_flush got req %0b cnt %0d v %0b i %h exp 0/0/0/%h", obs_req_a, COUNT_a, VALID_ID_a, INSTRUCTION_ID_a, NOP); end
    checks++; if (IMEM_REQ_a !== 1'b1 || IMEM_ADDR_a !== 32'h200) begin errors++; $display("FAIL coll_addr got %0b/%h exp 1/200", IMEM_REQ_a, IMEM_ADDR_a); end
    tick();
    checks++; if (VALID_ID_a !== 1'b0) begin errors++; $display("FAIL coll_r2 got %0b exp 0", VALID_ID_a); end
    tick();
    checks++; if (VALID_ID_a !== 1'b1 || PC_ID_a !== 32'h200 || INSTRUCTION_ID_a !== 32'h80) begin
      errors++; $display("FAIL coll_r3 got %0b/%h/%h exp 1/200/80", VALID_ID_a, PC_ID_a, INSTRUCTION_ID_a); end
    tick();
    checks++; if (VALID_ID_a !== 1'b1 || PC_ID_a !== 32'h204) begin errors++; $display("FAIL coll_next got %0b/%h exp 1/204", VALID_ID_a, PC_ID_a); end
    $display("test_redirect_collision done");
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc = 32'hFFFF_FFF0;
    int got = 0, n = 0, maxc = 0;
    logic wrap_ok = 0;
    do_reset(); ID_ready_a = 0;
    PCSrc_b = 1; PC_Branch_b = 32'hFFFF_FFF0;
    tick();
    PCSrc_b = 0;
    while (got < 12 && n < 400) begin
      ID_ready_b = 1'($urandom_range(0, 1));
      if (VALID_ID_b && ID_ready_b) begin
        checks++; if (PC_ID_b !== exp_pc || INSTRUCTION_ID_b !== (exp_pc >> 2)) begin
          errors++; $display("FAIL wrap_entry[%0d] got %h/%h exp %h/%h", got, PC_ID_b, INSTRUCTION_ID_b, exp_pc, exp_pc >> 2); end
        if (exp_pc == 32'h0 && PC_ID_b === 32'h0) wrap_ok = 1;
        exp_pc += 4; got++;
      end
      if (int'(COUNT_b) > maxc) maxc = int'(COUNT_b);
      tick(); n++;
    end
    checks++; if (got != 12 || !wrap_ok) begin errors++; $display("FAIL wrap_done got %0d wrap %0b exp 12/1", got, wrap_ok); end
    checks++; if (maxc > 8) begin errors++; $display("FAIL wrap_count got %0d exp <=8", maxc); end
    ID_ready_b = 1;
    $display("test_wrap done entries=%0d cycles=%0d", got, n);
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collision();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
